ascon_perm_sequencer: RTL and testbench

- Top-level control FSM for the Ascon AEAD core.
- Sequences the permutation datapath through initialisation, associated-data (AD) absorption, domain separation, message absorption, finalisation and tag output.
- Drives the round counter's load/enable/p12-select controls and consumes its next-is-last flag.
- Issues state-update selects to the datapath and valid/ready handshakes to the AD, message and tag interfaces.

---
 rtl/ascon_perm_sequencer.sv | 179 +++++++++++++++++
 tb/tb_ascon_perm_sequencer.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ascon_perm_sequencer.sv
// Top-level control FSM for the Ascon AEAD core: init, AD, domain separation, message, final, tag.
// Optional abort input enabled with `define ASCON_SEQ_ABORT_EN.
module ascon_perm_sequencer #(
  parameter int unsigned SEL_W   = 3,
  parameter int unsigned ROUND_W = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic             has_ad_i,
  input  logic             ad_valid_i,
  input  logic             ad_last_i,
  output logic             ad_ready_o,
  input  logic             msg_valid_i,
  input  logic             msg_last_i,
  output logic             msg_ready_o,
  output logic             tag_valid_o,
  input  logic             tag_ready_i,
  output logic             rc_load_o,
  output logic             rc_en_o,
  output logic             rc_sel_p12_o,
  input  logic             n_last_rnd_i,
  output logic             perm_en_o,
  output logic [SEL_W-1:0] state_sel_o,
  output logic             busy_o,
  output logic             done_o
`ifdef ASCON_SEQ_ABORT_EN
  ,
  input  logic             abort_i
`endif
);

  if (ROUND_W < 4 || SEL_W < 3) begin : g_param_check
    $error("ROUND_W must index 12 rounds and SEL_W must encode 7 selects");
  end

  localparam logic [2:0] SelNone    = 3'd0;
  localparam logic [2:0] SelIv      = 3'd1;
  localparam logic [2:0] SelKeyInit = 3'd2;
  localparam logic [2:0] SelAdXor   = 3'd3;
  localparam logic [2:0] SelDsep    = 3'd4;
  localparam logic [2:0] SelMsgXor  = 3'd5;
  localparam logic [2:0] SelKeyFin  = 3'd6;

  typedef enum logic [3:0] {
    StIdle, StLoadIv, StPermInit, StKeyInit, StWaitAd, StPermAd,
    StDsep, StWaitMsg, StPermMsg, StKeyFin, StPermFin, StTagOut
  } state_e;

  state_e     state_q, state_d;
  logic       last_q, last_d;
  logic       has_ad_q, has_ad_d;
  logic       ad_last_q, ad_last_d;
  logic [2:0] sel;

  function automatic logic is_perm(state_e s);
    return (s == StPermInit) || (s == StPermAd) || (s == StPermMsg) || (s == StPermFin);
  endfunction

  assign state_sel_o = SEL_W'(sel);

  always_comb begin
    state_d      = state_q;
    last_d       = last_q;
    has_ad_d     = has_ad_q;
    ad_last_d    = ad_last_q;
    sel          = SelNone;
    rc_load_o    = 1'b0;
    rc_en_o      = 1'b0;
    rc_sel_p12_o = 1'b0;
    done_o       = 1'b0;
    case (state_q)
      StIdle: begin
        if (start_i) begin
          state_d  = StLoadIv;
          has_ad_d = has_ad_i;
        end
      end
      StLoadIv: begin
        sel          = SelIv;
        rc_load_o    = 1'b1;
        rc_en_o      = 1'b1;
        rc_sel_p12_o = 1'b1;
        state_d      = StPermInit;
      end
      StPermInit, StPermAd, StPermMsg, StPermFin: begin
        rc_en_o = 1'b1;
        last_d  = n_last_rnd_i;
        // last_q marks the round after the counter's second-to-last flag: the final round
        if (last_q) begin
          last_d = 1'b0;
          case (state_q)
            StPermInit: state_d = StKeyInit;
            StPermAd:   state_d = ad_last_q ? StDsep : StWaitAd;
            StPermMsg:  state_d = StWaitMsg;
            default:    state_d = StTagOut;
          endcase
        end
      end
      StKeyInit: begin
        sel     = SelKeyInit;
        state_d = has_ad_q ? StWaitAd : StDsep;
      end
      StWaitAd: begin
        if (ad_valid_i) begin
          sel       = SelAdXor;
          rc_load_o = 1'b1;
          rc_en_o   = 1'b1;
          ad_last_d = ad_last_i;
          state_d   = StPermAd;
        end
      end
      StDsep: begin
        sel     = SelDsep;
        state_d = StWaitMsg;
      end
      StWaitMsg: begin
        if (msg_valid_i) begin
          sel = SelMsgXor;
          if (msg_last_i) begin
            state_d = StKeyFin;
          end else begin
            rc_load_o = 1'b1;
            rc_en_o   = 1'b1;
            state_d   = StPermMsg;
          end
        end
      end
      StKeyFin: begin
        sel          = SelKeyFin;
        rc_load_o    = 1'b1;
        rc_en_o      = 1'b1;
        rc_sel_p12_o = 1'b1;
        state_d      = StPermFin;
      end
      StTagOut: begin
        if (tag_ready_i) begin
          done_o  = 1'b1;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
`ifdef ASCON_SEQ_ABORT_EN
    if (abort_i) begin
      state_d  = StIdle;
      last_d   = 1'b0;
      has_ad_d = has_ad_q;
      done_o   = 1'b0;
    end
`endif
  end

  // Moore outputs are registered from the next state so they line up with state_q
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= StIdle;
      last_q      <= 1'b0;
      has_ad_q    <= 1'b0;
      ad_last_q   <= 1'b0;
      busy_o      <= 1'b0;
      ad_ready_o  <= 1'b0;
      msg_ready_o <= 1'b0;
      tag_valid_o <= 1'b0;
      perm_en_o   <= 1'b0;
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      has_ad_q    <= has_ad_d;
      ad_last_q   <= ad_last_d;
      busy_o      <= (state_d != StIdle);
      ad_ready_o  <= (state_d == StWaitAd);
      msg_ready_o <= (state_d == StWaitMsg);
      tag_valid_o <= (state_d == StTagOut);
      perm_en_o   <= is_perm(state_d);
    end
  end

endmodule

// File: tb/tb_ascon_perm_sequencer.sv
// Self-checking bench for ascon_perm_sequencer: transaction-level model of selects, round runs,
// busy cycles and handshakes under random stalls and out-of-state noise.
module tb_ascon_perm_sequencer;
  localparam int unsigned SEL_W   = 3;
  localparam int unsigned ROUND_W = 4;

  logic             clk_i = 1'b0;
  logic             rst_i = 1'b1;
  logic             start_i = 1'b0, has_ad_i = 1'b0;
  logic             ad_valid_i = 1'b0, ad_last_i = 1'b0, ad_ready_o;
  logic             msg_valid_i = 1'b0, msg_last_i = 1'b0, msg_ready_o;
  logic             tag_valid_o, tag_ready_i = 1'b0;
  logic             rc_load_o, rc_en_o, rc_sel_p12_o, n_last_rnd_i, perm_en_o;
  logic [SEL_W-1:0] state_sel_o;
  logic             busy_o, done_o;
`ifdef ASCON_SEQ_ABORT_EN
  logic             abort_i = 1'b0;
`endif

  ascon_perm_sequencer #(.SEL_W(SEL_W), .ROUND_W(ROUND_W)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .has_ad_i(has_ad_i),
    .ad_valid_i(ad_valid_i), .ad_last_i(ad_last_i), .ad_ready_o(ad_ready_o),
    .msg_valid_i(msg_valid_i), .msg_last_i(msg_last_i), .msg_ready_o(msg_ready_o),
    .tag_valid_o(tag_valid_o), .tag_ready_i(tag_ready_i),
    .rc_load_o(rc_load_o), .rc_en_o(rc_en_o), .rc_sel_p12_o(rc_sel_p12_o),
    .n_last_rnd_i(n_last_rnd_i), .perm_en_o(perm_en_o), .state_sel_o(state_sel_o),
    .busy_o(busy_o), .done_o(done_o)
`ifdef ASCON_SEQ_ABORT_EN
    , .abort_i(abort_i)
`endif
  );

  always #5 clk_i = ~clk_i;

  // External round counter: rounds remaining including the current one
  int rem = 0;
  assign n_last_rnd_i = (rem == 2);
  always @(posedge clk_i) begin
    if (rc_load_o) rem <= rc_sel_p12_o ? 12 : 6;
    else if (perm_en_o && rem > 0) rem <= rem - 1;
  end

  int tests = 0, failed = 0;
  int busy_cnt, tv_cnt, done_cnt, run_len;
  int sel_q[$], run_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic clear_mon();
    busy_cnt = 0; tv_cnt = 0; done_cnt = 0; run_len = 0;
    sel_q.delete(); run_q.delete();
  endtask

  // Sample the current cycle at the falling edge, then return just after the next rising edge
  task automatic tick();
    @(negedge clk_i);
    if (busy_o) busy_cnt++;
    if (tag_valid_o) tv_cnt++;
    if (done_o) done_cnt++;
    if (state_sel_o != '0) sel_q.push_back(int'(state_sel_o));
    if (perm_en_o) run_len++;
    else if (run_len != 0) begin
      run_q.push_back(run_len);
      run_len = 0;
    end
    @(posedge clk_i);
    #1;
  endtask

  // which: 0 = AD channel in use, 1 = message channel in use, 2 = tag phase
  task automatic noise(input int which, input bit en);
    if (!en) return;
    start_i = 1'($urandom_range(0, 1));
    if (which != 0) begin
      ad_valid_i = 1'($urandom_range(0, 1));
      ad_last_i  = 1'($urandom_range(0, 1));
    end
    if (which != 1) begin
      msg_valid_i = 1'($urandom_range(0, 1));
      msg_last_i  = 1'($urandom_range(0, 1));
    end
  endtask

  task automatic idle_inputs();
    start_i = 0; ad_valid_i = 0; ad_last_i = 0; msg_valid_i = 0; msg_last_i = 0; tag_ready_i = 0;
  endtask

  function automatic int pick(input int fixed);
    return (fixed < 0) ? int'($urandom_range(0, 4)) : fixed;
  endfunction

  task automatic run_txn(input string name, input bit has_ad, input int n_ad, input int n_msg,
                         input int stall, input int tag_stall, input bit nz);
    int exp_sel[$], exp_run[$];
    int exp_busy, s, guard;
    clear_mon();
    exp_sel = '{1, 2};
    exp_run = '{12};
    exp_busy = 1 + 12 + 1;
    idle_inputs();
    start_i = 1; has_ad_i = has_ad;
    tick();
    start_i = 0;
    if (has_ad) begin
      for (int i = 0; i < n_ad; i++) begin
        s = pick(stall);
        exp_busy += s + 1 + 6;
        exp_sel.push_back(3);
        exp_run.push_back(6);
        guard = 0;
        while (!ad_ready_o && guard < 200) begin
          ad_valid_i = 0; noise(0, nz); guard++; tick();
        end
        if (guard >= 200) check({name, " ad_ready timeout"}, 0, 1);
        repeat (s) begin
          ad_valid_i = 0; noise(0, nz); tick();
        end
        ad_valid_i = 1; ad_last_i = (i == n_ad - 1); noise(0, nz);
        tick();
        ad_valid_i = 0; ad_last_i = 0;
      end
    end
    exp_busy += 1;
    exp_sel.push_back(4);
    for (int j = 0; j < n_msg; j++) begin
      s = pick(stall);
      exp_busy += s + 1 + ((j == n_msg - 1) ? 0 : 6);
      exp_sel.push_back(5);
      if (j != n_msg - 1) exp_run.push_back(6);
      guard = 0;
      while (!msg_ready_o && guard < 200) begin
        msg_valid_i = 0; noise(1, nz); guard++; tick();
      end
      if (guard >= 200) check({name, " msg_ready timeout"}, 0, 1);
      repeat (s) begin
        msg_valid_i = 0; noise(1, nz); tick();
      end
      msg_valid_i = 1; msg_last_i = (j == n_msg - 1); noise(1, nz);
      tick();
      msg_valid_i = 0; msg_last_i = 0;
    end
    exp_sel.push_back(6);
    exp_run.push_back(12);
    exp_busy += 1 + 12 + tag_stall + 1;
    guard = 0;
    while (!tag_valid_o && guard < 200) begin
      noise(2, nz); guard++; tick();
    end
    if (guard >= 200) check({name, " tag_valid timeout"}, 0, 1);
    repeat (tag_stall) begin
      tag_ready_i = 0; noise(2, nz); tick();
    end
    idle_inputs();
    tag_ready_i = 1;
    tick();
    idle_inputs();
    tick();
    check({name, " busy cycles"}, busy_cnt, exp_busy);
    check({name, " tag_valid cycles"}, tv_cnt, tag_stall + 1);
    check({name, " done pulses"}, done_cnt, 1);
    check({name, " idle after"}, busy_o, 0);
    check({name, " sel count"}, sel_q.size(), exp_sel.size());
    for (int k = 0; k < exp_sel.size() && k < sel_q.size(); k++)
      check($sformatf("%s sel[%0d]", name, k), sel_q[k], exp_sel[k]);
    check({name, " run count"}, run_q.size(), exp_run.size());
    for (int k = 0; k < exp_run.size() && k < run_q.size(); k++)
      check($sformatf("%s run[%0d]", name, k), run_q[k], exp_run[k]);
  endtask

  initial begin
    int guard;
    rst_i = 1;
    tick();
    tick();
    rst_i = 0;
    check("reset busy", busy_o, 0);
    check("reset ad_ready", ad_ready_o, 0);
    check("reset msg_ready", msg_ready_o, 0);
    check("reset tag_valid", tag_valid_o, 0);
    check("reset perm_en", perm_en_o, 0);
    check("reset state_sel", state_sel_o, 0);
    check("reset rc_load", rc_load_o, 0);
    check("reset done", done_o, 0);

    run_txn("noad", 0, 0, 1, 0, 0, 0);
    check("noad total 30", busy_cnt, 30);
    run_txn("ad2msg2", 1, 2, 2, 0, 0, 0);
    run_txn("stall", 1, 1, 2, 5, 3, 0);
    run_txn("noise", 1, 2, 3, -1, 2, 1);

    // Reset in the middle of PERM_FIN round 5
    clear_mon();
    start_i = 1; has_ad_i = 0;
    tick();
    start_i = 0;
    guard = 0;
    while (!msg_ready_o && guard < 200) begin
      guard++; tick();
    end
    check("rst msg_ready reached", msg_ready_o, 1);
    msg_valid_i = 1; msg_last_i = 1;
    tick();
    idle_inputs();
    tick();
    repeat (4) tick();
    check("rst perm_en at round 5", perm_en_o, 1);
    rst_i = 1;
    tick();
    rst_i = 0;
    check("rst busy", busy_o, 0);
    check("rst perm_en", perm_en_o, 0);
    check("rst tag_valid", tag_valid_o, 0);
    run_txn("after rst", 0, 0, 1, 0, 0, 0);

`ifdef ASCON_SEQ_ABORT_EN
    clear_mon();
    start_i = 1; has_ad_i = 0;
    tick();
    start_i = 0;
    guard = 0;
    while (!msg_ready_o && guard < 200) begin
      guard++; tick();
    end
    check("abort msg_ready reached", msg_ready_o, 1);
    abort_i = 1; msg_valid_i = 1; msg_last_i = 1;
    tick();
    idle_inputs();
    check("abort busy", busy_o, 0);
    start_i = 1;
    tick();
    abort_i = 0; start_i = 0;
    check("abort+start busy", busy_o, 0);
    tick();
    check("abort done count", done_cnt, 0);
    run_txn("after abort", 1, 1, 1, -1, 1, 1);
`endif

    for (int t = 0; t < 6; t++)
      run_txn($sformatf("rnd%0d", t), 1'($urandom_range(0, 1)), int'($urandom_range(1, 3)),
              int'($urandom_range(1, 3)), -1, int'($urandom_range(0, 3)), 1);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
